// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Line-organised data-memory responder for the CPU MEM stage.
//                Accepts one 256-bit line read or write, acknowledges it after
//                a fixed latency, and counts completed reads and writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic [31:0]  rd_count_o,
    output logic [31:0]  wr_count_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              cnt;
    logic                    req_write;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [255:0]            req_data;
    logic [31:0]             rd_count;
    logic [31:0]             wr_count;
    logic                    wait_done;
    logic                    unused_addr_bits;

    logic [255:0]            mem [0:DEPTH-1];

    // Offset bits and bits above the index are deliberately dropped: lines
    // are aligned and addresses wrap modulo the array size.
    assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

    // Last WAIT cycle: this is where the access is performed.
    assign wait_done = (state == WAIT) && (cnt == 8'(LATENCY - 1));

    assign rd_count_o = rd_count;
    assign wr_count_o = wr_count;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the ack pulse, which is simply the ACK state.
    always_comb begin
        state_next = state;
        ack_o      = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                ack_o      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, latency counter, read data and saturating counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= 8'd0;
            req_write <= 1'b0;
            req_idx   <= '0;
            req_data  <= '0;
            data_o    <= '0;
            rd_count  <= 32'd0;
            wr_count  <= 32'd0;
        end else begin
            if (state == IDLE && enable_i) begin
                req_write <= write_i;
                req_idx   <= addr_i[DEPTH_LOG2+4:5];
                req_data  <= data_i;
                cnt       <= 8'd0;
            end
            if (state == WAIT) begin
                cnt <= cnt + 8'd1;
            end
            if (wait_done) begin
                if (req_write) begin
                    if (wr_count != 32'hFFFF_FFFF) begin
                        wr_count <= wr_count + 32'd1;
                    end
                end else begin
                    data_o <= mem[req_idx];
                    if (rd_count != 32'hFFFF_FFFF) begin
                        rd_count <= rd_count + 32'd1;
                    end
                end
            end
        end
    end

    // Storage write; contents survive reset, but a reset aborts the commit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wait_done && req_write) begin
            mem[req_idx] <= req_data;
        end
    end

endmodule
`default_nettype wire
